// File: rtl/lms_pkg.sv
// Shared constants and state encoding for the LMS weight-update stage.
package lms_pkg;

  localparam int LMS_NTAPS = 15;
  localparam int LMS_WW    = 10;
  // First shifter-bank lane carried on the packed buses (lane k sits at slot k-LMS_LANE_BASE).
  localparam int LMS_LANE_BASE = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_DONE   = 2'd2
  } lms_state_e;

endpackage

// File: rtl/lms_addsub_sat.sv
// Combinational WW-bit two's-complement add/sub; clamps when WT_SAT_EN is defined, wraps otherwise.
module lms_addsub_sat #(
  parameter int WW = 10
) (
  input  logic [WW-1:0] a_i,
  input  logic [WW-1:0] b_i,
  input  logic          sub_i,
  output logic [WW-1:0] y_o
);

  logic signed [WW:0] a_ext_s;
  logic signed [WW:0] b_ext_s;
  logic signed [WW:0] sum_s;
  logic               unused_msb_s;

  // Sign-extend by one bit so the raw result never overflows, then select clamp or wrap.
  always_comb begin
    a_ext_s = {a_i[WW-1], a_i};
    b_ext_s = {b_i[WW-1], b_i};
    if (sub_i) begin
      sum_s = a_ext_s - b_ext_s;
    end else begin
      sum_s = a_ext_s + b_ext_s;
    end
`ifdef WT_SAT_EN
    // Overflow shows up as disagreement between the guard bit and the result sign bit.
    if (sum_s[WW] != sum_s[WW-1]) begin
      if (sum_s[WW]) begin
        y_o = {1'b1, {(WW-1){1'b0}}};
      end else begin
        y_o = {1'b0, {(WW-1){1'b1}}};
      end
    end else begin
      y_o = sum_s[WW-1:0];
    end
`else
    y_o = sum_s[WW-1:0];
`endif
    unused_msb_s = sum_s[WW];
  end

endmodule

// File: rtl/lms_weight_update.sv
// LMS coefficient update: folds one beat of step terms into NTAPS weights, one tap per cycle.
// Build option WT_SAT_EN selects saturating instead of wrapping arithmetic.
module lms_weight_update
  import lms_pkg::*;
#(
  parameter int NTAPS = LMS_NTAPS,
  parameter int WW    = LMS_WW
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                sub,
  input  logic [NTAPS*WW-1:0] delta,
  output logic [NTAPS*WW-1:0] wt,
  output logic                busy,
  output logic                upd_done
);

  localparam int IDX_W = $clog2(NTAPS);

  lms_state_e          state_q;
  logic [IDX_W-1:0]    idx_q;
  logic [NTAPS*WW-1:0] hold_q;
  logic                sub_q;
  logic [NTAPS*WW-1:0] wt_q;
  logic                busy_q;
  logic                upd_done_q;

  logic [WW-1:0]       w_cur_s;
  logic [WW-1:0]       d_cur_s;
  logic [WW-1:0]       w_nxt_d;

  assign in_ready = (state_q == ST_IDLE) && !clr;
  assign wt       = wt_q;
  assign busy     = busy_q;
  assign upd_done = upd_done_q;

  // Operand mux steering the tap under update into the single shared adder.
  always_comb begin
    w_cur_s = wt_q[idx_q*WW +: WW];
    d_cur_s = hold_q[idx_q*WW +: WW];
  end

  lms_addsub_sat #(
    .WW (WW)
  ) u_addsub (
    .a_i   (w_cur_s),
    .b_i   (d_cur_s),
    .sub_i (sub_q),
    .y_o   (w_nxt_d)
  );

  // Control FSM and weight storage; clr outranks every state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      hold_q     <= '0;
      sub_q      <= 1'b0;
      wt_q       <= '0;
      busy_q     <= 1'b0;
      upd_done_q <= 1'b0;
    end else if (clr) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      wt_q       <= '0;
      busy_q     <= 1'b0;
      upd_done_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          upd_done_q <= 1'b0;
          if (in_valid) begin
            hold_q  <= delta;
            sub_q   <= sub;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= ST_UPDATE;
          end
        end
        ST_UPDATE: begin
          wt_q[idx_q*WW +: WW] <= w_nxt_d;
          if (idx_q == IDX_W'(NTAPS - 1)) begin
            upd_done_q <= 1'b1;
            state_q    <= ST_DONE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_DONE: begin
          upd_done_q <= 1'b0;
          busy_q     <= 1'b0;
          idx_q      <= '0;
          state_q    <= ST_IDLE;
        end
        default: begin
          upd_done_q <= 1'b0;
          busy_q     <= 1'b0;
          idx_q      <= '0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
